// File: rtl/tag_probe_arbiter.sv
// tag_probe_arbiter
// Merges processor read (AR) and write (AW) address requests into the single
// tag-probe stream of the DRAM cache controller. Every granted request issues
// one index probe and pushes a matching {is_write, addr, id} entry into the
// tag FIFO, so tag compare can pair the returned tags with their requests.
// Grants are throttled by FIFO almost-full and by an outstanding-probe credit
// counter that tag compare returns through retire_i.
//
// Configuration macro: TAG_ARB_READ_PRIORITY_EN
//   undefined (default) : round-robin between AR and AW when both are valid
//   defined             : strict read priority, AW granted only when AR idle

module tag_probe_arbiter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 16,
    parameter int INDEX_WIDTH     = 4,
    parameter int INDEX_LSB       = 6,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    // processor read request
    input  logic [ID_WIDTH-1:0]                  arid_i,
    input  logic [ADDR_WIDTH-1:0]                araddr_i,
    input  logic                                 arvalid_i,
    output logic                                 arready_o,

    // processor write request
    input  logic [ID_WIDTH-1:0]                  awid_i,
    input  logic [ADDR_WIDTH-1:0]                awaddr_i,
    input  logic                                 awvalid_i,
    output logic                                 awready_o,

    // tag probe to the memory controller
    output logic [ID_WIDTH-1:0]                  probe_id_o,
    output logic [INDEX_WIDTH-1:0]               probe_index_o,
    output logic                                 probe_valid_o,
    input  logic                                 probe_ready_i,

    // tag FIFO push
    input  logic                                 fifo_afull_i,
    output logic                                 fifo_write_en_o,
    output logic [ADDR_WIDTH+ID_WIDTH:0]         fifo_data_o,

    // credit return and status
    input  logic                                 retire_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FIFO_W = ADDR_WIDTH + ID_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,   // no probe presented
        PEND = 1'b1    // probe presented, waiting for probe_ready_i
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    err_q;
    logic                    err_d;

    logic                    slot_free;
    logic                    credit_ok;
    logic                    can_grant;
    logic                    sel_w;
    logic                    grant;
    logic [ID_WIDTH-1:0]     gnt_id;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [INDEX_WIDTH-1:0]  gnt_index;
    logic [FIFO_W-1:0]       gnt_entry;

    // ------------------------------------------------------------------
    // Grant qualification
    // ------------------------------------------------------------------

    // The probe slot can take a new request when empty or draining this cycle.
    assign slot_free = (state_q == IDLE) || probe_ready_i;
    assign credit_ok = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign can_grant = slot_free && !fifo_afull_i && credit_ok;

`ifdef TAG_ARB_READ_PRIORITY_EN
    // Strict read priority: a write only wins when no read is requesting.
    assign sel_w = awvalid_i && !arvalid_i;
`else
    // Which side the last grant went to; reset to 1 so the first contended
    // grant goes to AR.
    logic last_w_q;

    // Round-robin: on contention pick the side that was not granted last.
    assign sel_w = awvalid_i && (!arvalid_i || !last_w_q);
`endif

    // Readies are held low while reset is asserted, whatever the inputs do.
    assign arready_o = rst_n && can_grant && arvalid_i && !sel_w;
    assign awready_o = rst_n && can_grant && sel_w;
    assign grant     = arready_o || awready_o;

    // Payload of whichever side is being granted.
    assign gnt_id    = sel_w ? awid_i   : arid_i;
    assign gnt_addr  = sel_w ? awaddr_i : araddr_i;
    assign gnt_index = gnt_addr[INDEX_LSB +: INDEX_WIDTH];
    assign gnt_entry = {sel_w, gnt_addr, gnt_id};

    // ------------------------------------------------------------------
    // Probe handshake FSM
    // ------------------------------------------------------------------

    // State register for the probe slot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a grant always (re)loads the slot; otherwise a taken probe
    // empties it and an untaken one holds.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (grant) begin
                    state_d = PEND;
                end else if (probe_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign probe_valid_o = (state_q == PEND);

    // ------------------------------------------------------------------
    // Probe payload, FIFO push and arbitration history
    // ------------------------------------------------------------------

    // Capture the granted request into the probe and FIFO-push registers;
    // they hold their value while the probe waits for probe_ready_i.
    // NOTE: these are plain datapath flops (not a memory array), so they take
    // the asynchronous reset and come up at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_id_o      <= '0;
            probe_index_o   <= '0;
            fifo_write_en_o <= 1'b0;
            fifo_data_o     <= '0;
        end else begin
            fifo_write_en_o <= grant;
            if (grant) begin
                probe_id_o    <= gnt_id;
                probe_index_o <= gnt_index;
                fifo_data_o   <= gnt_entry;
            end
        end
    end

`ifdef TAG_ARB_READ_PRIORITY_EN
`else
    // Remember which side won the most recent grant for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_w_q <= 1'b1;
        end else if (grant) begin
            last_w_q <= sel_w;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outstanding-probe credits and retire error
    // ------------------------------------------------------------------

    // A grant takes a credit, a retire returns one; both together cancel.
    // A retire with nothing outstanding is a protocol error: the count stays
    // put and the sticky error flag is raised.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (retire_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
        case ({grant, retire_i})
            2'b10: cnt_d = cnt_q + CNT_W'(1);
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit counter and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: doc/tag_probe_arbiter.md
# tag_probe_arbiter

Arbitrates processor read (AR) and write (AW) address requests into the single tag-probe stream of the DRAM cache controller. Each granted request issues one index probe to the memory controller and pushes a matching `{is_write, addr, id}` entry into the tag FIFO in the same order, so tag compare can pair returned tags with requests. Grants are throttled by FIFO almost-full and by an outstanding-probe credit counter that is returned by tag compare.

## Interface
- `ADDR_WIDTH`, 64, processor address width
- `ID_WIDTH`, 16, AXI ID width
- `INDEX_WIDTH`, 4, cache set index width
- `INDEX_LSB`, 6, bit position of index LSB in address
- `MAX_OUTSTANDING`, 8, max probes issued and not yet retired (≥1)

Ports:
- `clk` in 1: the only clock. Reset `rst_n` is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset
- `arid_i` in ID_WIDTH / `araddr_i` in ADDR_WIDTH / `arvalid_i` in 1 / `arready_o` out 1: processor read request
- `awid_i` in ID_WIDTH / `awaddr_i` in ADDR_WIDTH / `awvalid_i` in 1 / `awready_o` out 1: processor write request
- `probe_id_o` out ID_WIDTH / `probe_index_o` out INDEX_WIDTH / `probe_valid_o` out 1 / `probe_ready_i` in 1: tag probe to memory controller
- `fifo_afull_i` in 1: tag FIFO almost full
- `fifo_write_en_o` out 1 / `fifo_data_o` out ADDR_WIDTH+ID_WIDTH+1: `{is_write, addr, id}` push to tag FIFO
- `retire_i` in 1: tag compare consumed one FIFO entry (credit return)
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current credit usage
- `err_o` out 1: sticky, `retire_i` seen with zero outstanding

## Operation
- `can_grant = (!probe_valid_o || probe_ready_i) && !fifo_afull_i && (outstanding_o < MAX_OUTSTANDING)`.
- Arbitration (combinational): only AR valid -> AR; only AW valid -> AW; both -> side not granted last (`last_w` register). `arready_o`/`awready_o` = `can_grant` && selected side. At most one ready high per cycle.
- On grant (valid && ready): register `probe_id_o`=id, `probe_index_o`=`addr[INDEX_LSB +: INDEX_WIDTH]`, assert `probe_valid_o`; `fifo_write_en_o` pulses one cycle with `fifo_data_o={is_write, addr, id}`; `last_w` <= is_write; outstanding +1.
- States: IDLE (`probe_valid_o`=0), PEND (`probe_valid_o`=1). IDLE->PEND on grant. PEND->IDLE on `probe_ready_i` with no grant; PEND->PEND on `probe_ready_i` with grant (back-to-back) or on no `probe_ready_i` (outputs held stable).
- Credits: grant && `retire_i` -> unchanged; `retire_i` alone -> −1; `retire_i` at 0 -> stays 0, `err_o` set until reset.
- `fifo_afull_i` only blocks new grants; a pending probe still completes.

## Timing
- Reset values: `probe_valid_o`=0, `probe_id_o`=0, `probe_index_o`=0, `fifo_write_en_o`=0, `fifo_data_o`=0, `outstanding_o`=0, `err_o`=0, `last_w`=1 (first contended grant goes to AR); `arready_o`/`awready_o`=0 during reset.
- Ready depends on valid (combinational); no comb path from `probe_ready_i` to outputs other than `arready_o`/`awready_o`.
- Latency: grant in cycle N -> `probe_valid_o` and `fifo_write_en_o` in N+1. Throughput 1 probe/cycle when `probe_ready_i` held high.
- `outstanding_o` updates the cycle after grant/retire. Reset mid-operation drops pending probe and credits immediately.

## Configuration
- `TAG_ARB_READ_PRIORITY_EN`: defined -> reads win whenever `arvalid_i`=1 (strict priority, `last_w` unused); writes granted only when AR idle. Undefined -> round-robin as above.

## Test plan
- Single read `araddr_i`=0x0000_0000_0000_01C0, id 0x12, `probe_ready_i`=1 -> `arready_o`=1 cycle 0; cycle 1 `probe_index_o`=0x7, `probe_id_o`=0x12, `fifo_data_o`={0, addr, 0x12}, `outstanding_o`=1.
- AR and AW both valid 4 cycles -> grants alternate R,W,R,W (with macro: R,R,R,R, AW starved).
- 8 grants, no `retire_i` -> `outstanding_o`=8, both readys 0; one `retire_i` -> next cycle one grant allowed.
- `probe_ready_i`=0 for 3 cycles after grant -> probe outputs stable, no new ready; then `probe_ready_i`=1 with AR valid -> back-to-back grant, `probe_valid_o` stays 1.
- `fifo_afull_i`=1 -> no readys; grant and `retire_i` same cycle -> count unchanged; `retire_i` at 0 -> `err_o`=1 sticky; `rst_n` low mid-PEND -> all outputs 0 asynchronously.
